mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between instruction fetch (IF) and data load/store (DM) requesters.
- Sequences each access through a registered state machine, with one transaction outstanding.
- Arbitrates with DM priority plus an IF anti-starvation guard, times out hung accesses, and rejects misaligned data accesses.
- Sits between the fetch unit / load-store path and the shared memory; its stall outputs freeze the processor pipeline.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_DM_STREAK, 4, consecutive DM grants allowed while IF waits before IF is forced
TIMEOUT_CYCLES, 16, cycles in WAIT without mem_rvalid before error completion (>=2)

Ports:
clock  in  1  system clock, all logic on rising edge
reset_signal  in  1  synchronous, active-high reset
if_req  in  1  fetch request, level, held until if_ack
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle completion pulse to fetch
if_rdata  out  DATA_W  fetched word, valid with if_ack, held until next if_ack
dm_req  in  1  data request, level, held until dm_ack
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_ack  out  1  one-cycle completion pulse to data port
dm_rdata  out  DATA_W  load data, valid with dm_ack, held until next dm_ack
resp_err  out  1  pulses with an ack when that completion is an error
mem_en  out  1  one-cycle memory command strobe
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address, held from ISSUE through WAIT
mem_wdata  out  DATA_W  memory write data, held from ISSUE through WAIT
mem_rvalid  in  1  memory completion for reads and writes
mem_rdata  in  DATA_W  memory read data, valid with mem_rvalid
pipeline_stall  out  1  (if_req & ~if_ack) | (dm_req & ~dm_ack)
busy  out  1  state != IDLE

Behaviour:
- Reset state: state=IDLE; streak=0; timeout counter=0.
- All registered outputs are 0 at reset, including if_rdata and dm_rdata.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs except pipeline_stall and busy are registered.
- IDLE:
  - Requests are sampled only in IDLE.
  - If no request, stay in IDLE.
  - Otherwise pick an owner and latch owner, addr, we and wdata (IF: we=0).
  - DM misaligned (dm_addr[1:0]!=0): go to DONE with err=1 and no memory access.
  - All other grants go to ISSUE.
- ISSUE (1 cycle): mem_en=1 and mem_we=latched we; go to WAIT; clear timeout counter.
- WAIT:
  - mem_rvalid=1: capture mem_rdata (reads only), go to DONE with err=0.
  - Counter reaches TIMEOUT_CYCLES-1 without rvalid: go to DONE with err=1; read data forced to 0.
  - Otherwise increment the counter.
- DONE (1 cycle): owner's ack=1; resp_err=err; owner's rdata updated (loads/fetches only; stores leave dm_rdata unchanged); next state IDLE.
- No re-arbitration happens in the DONE cycle, which prevents double service of a req still high during its ack.
- Latency, req seen in IDLE at cycle 0 with memory rvalid N cycles after mem_en (N>=1):
  - mem_en at cycle 1;
  - ack at cycle 2+N;
  - next grant no earlier than cycle 3+N.
- Arbitration:
  - DM wins a simultaneous request unless streak==MAX_DM_STREAK and if_req=1; in that case IF wins.
  - streak increments on a DM grant made while if_req=1, saturating at MAX_DM_STREAK.
  - streak clears on an IF grant, or on a DM grant made while if_req=0.
- mem_rvalid outside WAIT, including during ISSUE, is ignored. The memory must never complete a timed-out access.
- A requester dropping req before its ack is a protocol violation. The transaction still completes and the ack still pulses.
- Reset mid-operation abandons the in-flight access: state=IDLE immediately, no ack issued, later stray rvalid ignored.
- Addresses pass through unmodified apart from the DM misalignment check; IF alignment is not checked.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, DONE};
  - owner enum {OWN_IF, OWN_DM};
  - constant ERR_RDATA = 0.
- One sub-module, mem_arb_pick, covers the combinational winner select plus the registered streak counter. Its inputs are if_req, dm_req and a grant strobe; its output is the owner.
- The top contains the FSM, the timeout counter, the latches and the ack/rdata registers.

Test Plan:
1. IF only, if_addr=0x100; memory returns 0x2402000A with rvalid 1 cycle after mem_en -> mem_en at cycle 1; if_ack and if_rdata=0x2402000A at cycle 3; resp_err=0; pipeline_stall high during cycles 0-2.
2. if_req and dm_req both held high, DM store to 0x40 of 0xCAFEF00D -> four DM grants, then one IF grant, then DM again; mem_we=1 and mem_wdata=0xCAFEF00D on each DM mem_en.
3. DM load at 0x42 -> no mem_en; dm_ack with resp_err=1 and dm_rdata=0 at cycle 1.
4. IF read, memory never responds -> mem_en exactly once; if_ack with resp_err=1 and if_rdata=0 when the counter reaches TIMEOUT_CYCLES-1 (16 WAIT cycles after ISSUE); busy then drops.
5. reset_signal pulsed in the WAIT cycle after mem_en, then rvalid arrives -> no ack, outputs 0, state IDLE, stray rvalid ignored; a following IF request completes normally.
6. DM load with req held high through its dm_ack -> exactly one memory access per ack; second access mem_en one cycle after returning to IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the instruction/data memory port
//            arbiter (FSM states, transaction owner, error read data).
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Transaction sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Which requester owns the in-flight transaction
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // Read data returned on an error completion
    localparam int ERR_RDATA = 0;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pick
// Purpose  : Winner select for the shared memory port. Data port has priority;
//            a streak counter forces one fetch grant after MAX_DM_STREAK data
//            grants were made while fetch was waiting.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_DM_STREAK = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   if_req,
    input  logic   dm_req,
    input  logic   grant,
    output owner_t owner
);

    localparam int SW = (MAX_DM_STREAK > 0) ? $clog2(MAX_DM_STREAK + 1) : 1;
    localparam logic [SW-1:0] C_STREAK_MAX = SW'(MAX_DM_STREAK);

    logic [SW-1:0] r_streak;
    logic          w_force_if;

    // Data wins unless fetch has been passed over too many times in a row
    always_comb begin
        w_force_if = if_req && (r_streak == C_STREAK_MAX);
        owner      = (dm_req && !w_force_if) ? OWN_DM : OWN_IF;
    end

    // Count data grants taken while fetch waited; saturate at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak <= '0;
        end else if (grant) begin
            if (owner == OWN_DM && if_req) begin
                if (r_streak != C_STREAK_MAX) begin
                    r_streak <= r_streak + 1'b1;
                end
            end else begin
                r_streak <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port variable-latency memory between fetch and
//            load/store. One transaction outstanding, sequenced through
//            IDLE -> ISSUE -> WAIT -> DONE, with timeout and misalignment
//            error completions.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_DM_STREAK  = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset_signal,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pipeline_stall,
    output logic              busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    arb_state_t        r_state, w_state_nxt;
    owner_t            w_pick, r_owner;
    logic              w_grant, w_misaligned;
    logic              w_done, w_done_err, w_done_dm, w_done_read;
    logic [DATA_W-1:0] w_done_data;
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic              r_mem_en, r_mem_we;
    logic              r_if_ack, r_dm_ack, r_err;
    logic [DATA_W-1:0] r_if_rdata, r_dm_rdata;

    mem_arb_pick #(
        .MAX_DM_STREAK (MAX_DM_STREAK)
    ) u_pick (
        .clk    (clock),
        .rst    (reset_signal),
        .if_req (if_req),
        .dm_req (dm_req),
        .grant  (w_grant),
        .owner  (w_pick)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset_signal) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; requests are only looked at in IDLE so DONE never re-grants
    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_misaligned = 1'b0;
        case (r_state)
            IDLE: begin
                if (if_req || dm_req) begin
                    w_grant = 1'b1;
                    if (w_pick == OWN_DM && dm_addr[1:0] != 2'b00) begin
                        w_misaligned = 1'b1;
                        w_state_nxt  = DONE;
                    end else begin
                        w_state_nxt = ISSUE;
                    end
                end
            end
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (w_done) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Completion decode: misaligned grant, memory response, or timeout
    always_comb begin
        w_done      = 1'b0;
        w_done_err  = 1'b0;
        w_done_dm   = 1'b0;
        w_done_read = 1'b0;
        w_done_data = mem_rdata;
        if (w_misaligned) begin
            w_done      = 1'b1;
            w_done_err  = 1'b1;
            w_done_dm   = 1'b1;
            w_done_read = !dm_we;
        end else if (r_state == WAIT && (mem_rvalid || r_cnt == C_CNT_LAST)) begin
            w_done      = 1'b1;
            w_done_err  = !mem_rvalid;
            w_done_dm   = (r_owner == OWN_DM);
            w_done_read = !r_we;
        end
        if (w_done_err) begin
            w_done_data = DATA_W'(ERR_RDATA);
        end
    end

    // Latch the granted transaction; these also drive the memory address/data
    always_ff @(posedge clock) begin
        if (reset_signal) begin
            r_owner <= OWN_IF;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_owner <= w_pick;
            if (w_pick == OWN_DM) begin
                r_addr  <= dm_addr;
                r_we    <= dm_we;
                r_wdata <= dm_wdata;
            end else begin
                r_addr  <= if_addr;
                r_we    <= 1'b0;
                r_wdata <= '0;
            end
        end
    end

    // One-cycle memory command, high for the ISSUE cycle
    always_ff @(posedge clock) begin
        if (reset_signal) begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
        end else begin
            r_mem_en <= w_grant && !w_misaligned;
            r_mem_we <= w_grant && !w_misaligned && (w_pick == OWN_DM) && dm_we;
        end
    end

    // WAIT-cycle counter, cleared while issuing
    always_ff @(posedge clock) begin
        if (reset_signal) begin
            r_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_cnt <= '0;
        end else if (r_state == WAIT && !w_done) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Ack/error pulses and held read data, all landing in the DONE cycle
    always_ff @(posedge clock) begin
        if (reset_signal) begin
            r_if_ack   <= 1'b0;
            r_dm_ack   <= 1'b0;
            r_err      <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_if_ack <= w_done && !w_done_dm;
            r_dm_ack <= w_done && w_done_dm;
            r_err    <= w_done && w_done_err;
            if (w_done && !w_done_dm) begin
                r_if_rdata <= w_done_data;
            end
            if (w_done && w_done_dm && w_done_read) begin
                r_dm_rdata <= w_done_data;
            end
        end
    end

    assign if_ack         = r_if_ack;
    assign if_rdata       = r_if_rdata;
    assign dm_ack         = r_dm_ack;
    assign dm_rdata       = r_dm_rdata;
    assign resp_err       = r_err;
    assign mem_en         = r_mem_en;
    assign mem_we         = r_mem_we;
    assign mem_addr       = r_addr;
    assign mem_wdata      = r_wdata;
    assign pipeline_stall = (if_req & ~r_if_ack) | (dm_req & ~r_dm_ack);
    assign busy           = (r_state != IDLE);

endmodule
`default_nettype wire
